// File: rtl/lcd_text_ctrl.sv
// HD44780-style character LCD refresher: powers up, initialises, then continuously streams a ROWS x COLS frame buffer.
// Optional macro LCD_NIBBLE_MODE_EN selects the 4-bit bus (each byte sent as two nibble transactions).
module lcd_text_ctrl #(
  parameter int ROWS          = 2,
  parameter int COLS          = 16,
  parameter int TICK_CYCLES   = 50000,
  parameter int POWERUP_TICKS = 40,
  localparam int CELLS        = ROWS * COLS,
  localparam int AW           = $clog2(CELLS),
`ifdef LCD_NIBBLE_MODE_EN
  localparam int DW           = 4
`else
  localparam int DW           = 8
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_char,
  output logic          init_done,
  output logic          frame_done,
  output logic          rs,
  output logic          rw,
  output logic          enable,
  output logic [DW-1:0] data
);

`ifdef LCD_NIBBLE_MODE_EN
  localparam int INIT_LEN = 8;
`else
  localparam int INIT_LEN = 4;
`endif
  localparam int TCW = $clog2(TICK_CYCLES + 1);
  localparam int PW  = $clog2(POWERUP_TICKS + 1);
  localparam int SW  = $clog2(COLS + 1);
  localparam int RW  = $clog2(ROWS + 1);

  typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_SET_ADDR, ST_WRITE_CHAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t          state_q;
  phase_t          phase_q;
  logic [TCW-1:0]  tick_cnt_q;
  logic [PW-1:0]   pu_cnt_q;
  logic [SW-1:0]   step_q;
  logic [RW-1:0]   row_q;
  logic            rs_q, en_q, init_done_q, frame_done_q;
  logic [DW-1:0]   data_q;
  logic [7:0]      fb_q [CELLS];

  logic            tick, pu_done, load, pulse_tick, last_half;
  logic [AW-1:0]   rd_idx;
  logic [7:0]      cur_byte;
  logic [DW-1:0]   bus_word;

  // Init command for a given step; in nibble mode steps 0..3 only use the high nibble.
  function automatic logic [7:0] init_byte(input logic [SW-1:0] s);
`ifdef LCD_NIBBLE_MODE_EN
    case (s)
      0, 1, 2: init_byte = 8'h30;
      3:       init_byte = 8'h20;
      4:       init_byte = 8'h28;
      5:       init_byte = 8'h0C;
      6:       init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
`else
    case (s)
      0:       init_byte = 8'h38;
      1:       init_byte = 8'h0C;
      2:       init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
`endif
  endfunction

  function automatic logic [7:0] row_base(input logic [RW-1:0] r);
    case (r)
      0:       row_base = 8'h00;
      1:       row_base = 8'h40;
      2:       row_base = 8'h14;
      default: row_base = 8'h54;
    endcase
  endfunction

  assign tick       = (tick_cnt_q == TCW'(TICK_CYCLES - 1));
  assign pu_done    = (pu_cnt_q == PW'(POWERUP_TICKS - 1));
  assign load       = tick && ((state_q == ST_POWERUP) ? pu_done : (phase_q == PH_HOLD));
  assign pulse_tick = tick && (state_q != ST_POWERUP) && (phase_q == PH_PULSE);
  assign rd_idx     = AW'(int'(row_q) * COLS + int'(step_q));

  always_comb begin
    cur_byte = init_byte(step_q);
    case (state_q)
      ST_SET_ADDR:   cur_byte = 8'h80 | row_base(row_q);
      ST_WRITE_CHAR: cur_byte = fb_q[rd_idx];
      default:       cur_byte = init_byte(step_q);
    endcase
  end

`ifdef LCD_NIBBLE_MODE_EN
  logic       half_q, single;
  logic [7:0] byte_q;

  // The byte is latched on its first SETUP so both nibbles come from one buffer sample.
  assign single    = (state_q == ST_INIT) && (step_q < SW'(4));
  assign last_half = half_q || single;
  assign bus_word  = half_q ? byte_q[3:0] : cur_byte[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_q <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      if (pulse_tick)       half_q <= ~last_half;
      if (load && !half_q)  byte_q <= cur_byte;
    end
  end
`else
  assign last_half = 1'b1;
  assign bus_word  = cur_byte;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) fb_q[i] <= 8'h20;
    end else if (wr_valid && wr_ready && (int'(wr_addr) < CELLS)) begin
      fb_q[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_POWERUP;
      phase_q      <= PH_SETUP;
      pu_cnt_q     <= '0;
      step_q       <= '0;
      row_q        <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (tick && state_q == ST_POWERUP) begin
        if (pu_done) state_q <= ST_INIT;
        else         pu_cnt_q <= pu_cnt_q + 1'b1;
      end else if (tick) begin
        case (phase_q)
          PH_SETUP: begin en_q <= 1'b1; phase_q <= PH_PULSE; end
          PH_PULSE: begin en_q <= 1'b0; phase_q <= PH_HOLD;  end
          default:  phase_q <= PH_SETUP;
        endcase
      end
      // rs/data change only when entering SETUP; they then hold through PULSE and HOLD.
      if (load) begin
        rs_q   <= (state_q == ST_WRITE_CHAR);
        data_q <= bus_word;
      end
      // Position advances on entry to HOLD so the next SETUP already sees the new cell.
      if (pulse_tick && last_half) begin
        case (state_q)
          ST_INIT: begin
            if (step_q == SW'(INIT_LEN - 1)) begin
              state_q     <= ST_SET_ADDR;
              step_q      <= '0;
              row_q       <= '0;
              init_done_q <= 1'b1;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
          ST_SET_ADDR: begin
            state_q <= ST_WRITE_CHAR;
            step_q  <= '0;
          end
          ST_WRITE_CHAR: begin
            if (step_q == SW'(COLS - 1)) begin
              step_q  <= '0;
              state_q <= ST_SET_ADDR;
              if (row_q == RW'(ROWS - 1)) begin
                row_q        <= '0;
                frame_done_q <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_ready   = ~reset;
  assign rw         = 1'b0;
  assign rs         = rs_q;
  assign enable     = en_q;
  assign data       = data_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl (8-bit bus, 2x16, 4 clks per tick, 2 power-up ticks).
module tb_lcd_text_ctrl;
  localparam int ROWS          = 2;
  localparam int COLS          = 16;
  localparam int TICK_CYCLES   = 4;
  localparam int POWERUP_TICKS = 2;
  localparam int AW            = $clog2(ROWS * COLS);
`ifdef LCD_NIBBLE_MODE_EN
  localparam int DW = 4;
`else
  localparam int DW = 8;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_char;
  logic          init_done, frame_done, rs, rw, enable;
  logic [DW-1:0] data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lcd_text_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .TICK_CYCLES(TICK_CYCLES), .POWERUP_TICKS(POWERUP_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_char(wr_char), .init_done(init_done), .frame_done(frame_done),
    .rs(rs), .rw(rw), .enable(enable), .data(data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the first negedge where enable has just risen (PULSE of a transaction).
  task automatic wait_txn(output logic t_rs, output logic [7:0] t_data);
    logic prev;
    bit   seen;
    seen = 1'b0;
    prev = enable;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (enable && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = enable;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $error("FAIL txn_timeout: observed no enable pulse, required one within 60 clks");
    end
    t_rs   = rs;
    t_data = 8'(data);
  endtask

  task automatic expect_txn(input string tag, input logic exp_rs, input logic [7:0] exp_data);
    logic       t_rs;
    logic [7:0] t_data;
    wait_txn(t_rs, t_data);
    check(tag, 32'({t_rs, t_data}), 32'({exp_rs, exp_data}));
  endtask

  task automatic expect_powerup();
    int cyc;
    cyc = 0;
    while (data == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("powerup_clks", cyc, POWERUP_TICKS * TICK_CYCLES);
    check("setup_enable", 32'(enable), 0);
    check("setup_rs", 32'(rs), 0);
  endtask

  task automatic expect_init();
    expect_txn("init_38", 1'b0, 8'h38);
    expect_txn("init_0C", 1'b0, 8'h0C);
    expect_txn("init_06", 1'b0, 8'h06);
    expect_txn("init_01", 1'b0, 8'h01);
    check("init_done_pulse", 32'(init_done), 0);
    repeat (3) @(negedge clk);
    check("init_done_prehold", 32'(init_done), 0);
    check("enable_prehold", 32'(enable), 1);
    @(negedge clk);
    check("init_done_hold", 32'(init_done), 1);
    check("enable_hold", 32'(enable), 0);
  endtask

  task automatic expect_frame_done();
    repeat (3) @(negedge clk);
    check("frame_done_early", 32'(frame_done), 0);
    @(negedge clk);
    check("frame_done_hold", 32'(frame_done), 1);
    @(negedge clk);
    check("frame_done_width", 32'(frame_done), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] c);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_char  = c;
    check("wr_ready", 32'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_char  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rs", 32'(rs), 0);
    check("rst_rw", 32'(rw), 0);
    check("rst_enable", 32'(enable), 0);
    check("rst_data", 32'(data), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    reset = 1'b0;

    expect_powerup();
    expect_init();

    // Frame 1: untouched buffer.
    expect_txn("f1_addr_row0", 1'b0, 8'h80);
    for (int i = 0; i < COLS; i++) expect_txn("f1_row0", 1'b1, 8'h20);
    expect_txn("f1_addr_row1", 1'b0, 8'hC0);
    for (int i = 0; i < COLS; i++) expect_txn("f1_row1", 1'b1, 8'h20);
    expect_frame_done();

    // Frame 2: cell 17 written during row 0, cell 0 written during row 1.
    expect_txn("f2_addr_row0", 1'b0, 8'h80);
    do_write(AW'(17), 8'h41);
    for (int i = 0; i < COLS; i++) expect_txn("f2_row0", 1'b1, 8'h20);
    expect_txn("f2_addr_row1", 1'b0, 8'hC0);
    do_write(AW'(0), 8'h5A);
    expect_txn("f2_row1_c0", 1'b1, 8'h20);
    expect_txn("f2_row1_c1", 1'b1, 8'h41);
    for (int i = 2; i < COLS; i++) expect_txn("f2_row1", 1'b1, 8'h20);
    expect_frame_done();

    // Frame 3: cell 0 now visible, cell 17 persists.
    expect_txn("f3_addr_row0", 1'b0, 8'h80);
    expect_txn("f3_row0_c0", 1'b1, 8'h5A);
    for (int i = 1; i < COLS; i++) expect_txn("f3_row0", 1'b1, 8'h20);
    expect_txn("f3_addr_row1", 1'b0, 8'hC0);
    expect_txn("f3_row1_c0", 1'b1, 8'h20);
    expect_txn("f3_row1_c1", 1'b1, 8'h41);

    // Reset during the PULSE of the transaction just observed.
    check("pulse_enable", 32'(enable), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_enable", 32'(enable), 0);
    check("abort_data", 32'(data), 0);
    check("abort_rs", 32'(rs), 0);
    check("abort_init_done", 32'(init_done), 0);
    check("abort_wr_ready", 32'(wr_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    expect_powerup();
    expect_init();
    expect_txn("r_addr_row0", 1'b0, 8'h80);
    expect_txn("r_row0_c0", 1'b1, 8'h20);
    for (int i = 1; i < COLS; i++) expect_txn("r_row0", 1'b1, 8'h20);
    expect_txn("r_addr_row1", 1'b0, 8'hC0);
    expect_txn("r_row1_c0", 1'b1, 8'h20);
    expect_txn("r_row1_c1", 1'b1, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
